clint_responder: RTL and testbench

Core-local interruptor (CLINT) that answers the core's data-bus requests in the timer/software-interrupt window and drives the core's `trint` and `swint` inputs. It sits on the data-bus side of the interconnect, next to main memory, as the responder to the core's `dreq`/`dresp` initiator. It owns `msip`, `mtimecmp` and a free-running `mtime`.

---
 rtl/clint_responder_if.sv | 25 ++
 rtl/clint_responder.sv | 116 +++++++++++
 tb/tb_clint_responder.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/clint_responder_if.sv
// Data-bus request/response bundle between the core (master) and a
// data-side responder such as the CLINT (slave).
interface clint_responder_if;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);

endinterface

// File: rtl/clint_responder.sv
// Core-local interruptor: msip / mtimecmp / free-running mtime behind a
// 64 KiB data-bus window, driving the core's timer and software interrupts.
module clint_responder #(
  parameter logic [63:0] BASE     = 64'h0000_0000_0200_0000,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic               clk,
  input  logic               reset,
  clint_responder_if.slave   bus,
  output logic               trint,
  output logic               swint
);

  localparam logic [12:0]   IDX_MSIP     = 13'h0000;
  localparam logic [12:0]   IDX_MTIMECMP = 13'h0800;
  localparam logic [12:0]   IDX_MTIME    = 13'h17FF;
  localparam int            PW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX    = PW'(TICK_DIV - 1);

  typedef enum logic {IDLE, RESP} state_t;

  state_t        state, state_nx;
  logic          hit, accept, commit;
  logic [12:0]   req_idx, idx_q;
  logic [7:0]    strb_q;
  logic [63:0]   wdata_q, rdata_q, rd_val;
  logic [63:0]   mtime, mtimecmp, mtime_inc;
  logic          msip;
  logic [PW-1:0] presc;
  logic          tick;
  logic          unused_bits;

  assign hit         = (bus.dreq.addr[63:16] == BASE[63:16]);
  assign req_idx     = bus.dreq.addr[15:3];
  assign unused_bits = ^{bus.dreq.addr[2:0], bus.dreq.size};

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [7:0]  strb);
    logic [63:0] v;
    v = old_v;
    for (int i = 0; i < 8; i++)
      if (strb[i]) v[8*i +: 8] = new_v[8*i +: 8];
    return v;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_nx = state;
    accept   = 1'b0;
    commit   = 1'b0;
    unique case (state)
      IDLE: if (bus.dreq.valid && hit) begin
        accept   = 1'b1;
        state_nx = RESP;
      end
      RESP: begin
        commit   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rd_val = 64'h0;
    unique case (req_idx)
      IDX_MSIP:     rd_val = {63'h0, msip};
      IDX_MTIMECMP: rd_val = mtimecmp;
      IDX_MTIME:    rd_val = mtime;
      default:      rd_val = 64'h0;
    endcase
  end

  assign bus.dresp = {state == RESP, state == RESP, (state == RESP) ? rdata_q : 64'h0};

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // NOTE: request/read-data holding registers are not reset; the response is gated by state.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= req_idx;
      strb_q  <= bus.dreq.strobe;
      wdata_q <= bus.dreq.data;
      rdata_q <= rd_val;
    end
  end

  assign tick      = (presc == PRESC_MAX);
  assign mtime_inc = mtime + {63'h0, tick};

  // A bus write to mtime overrides only its strobed bytes of the incremented value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc    <= '0;
      mtime    <= 64'h0;
      mtimecmp <= '1;
      msip     <= 1'b0;
      trint    <= 1'b0;
      swint    <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      trint <= (mtime >= mtimecmp);
      swint <= msip;
      if (commit && idx_q == IDX_MTIME) mtime <= merge_bytes(mtime_inc, wdata_q, strb_q);
      else                              mtime <= mtime_inc;
      if (commit && idx_q == IDX_MTIMECMP) mtimecmp <= merge_bytes(mtimecmp, wdata_q, strb_q);
      if (commit && idx_q == IDX_MSIP && strb_q[0]) msip <= wdata_q[0];
    end
  end

endmodule

// File: tb/tb_clint_responder.sv
// Randomized scoreboard bench for clint_responder: two instances (TICK_DIV 1 and 3)
// share one request stream and are checked against a per-cycle behavioural model.
module tb_clint_responder;

  localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  clint_responder_if b1 ();
  clint_responder_if b3 ();
  assign b3.dreq = b1.dreq;

  logic trint1, swint1, trint3, swint3;

  clint_responder #(.BASE(BASE), .TICK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1), .trint(trint1), .swint(swint1));
  clint_responder #(.BASE(BASE), .TICK_DIV(3)) dut3 (
    .clk(clk), .reset(reset), .bus(b3), .trint(trint3), .swint(swint3));

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t exp0[$];
  exp_t exp1[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   mon_en  = 1'b0;

  // Reference model state: register values as seen between clock edges.
  logic [63:0] m_mtime[2];
  logic [63:0] m_cmp[2];
  logic        m_msip[2];
  logic        m_trint[2];
  logic        m_swint[2];
  int          m_presc[2];
  logic [15:0] p_off;
  logic [7:0]  p_strb;
  logic [63:0] p_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int divof(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [63:0] model_read(input int k, input logic [15:0] off);
    if (off == 16'h0000) return {63'h0, m_msip[k]};
    if (off == 16'h4000) return m_cmp[k];
    if (off == 16'hBFF8) return m_mtime[k];
    return 64'h0;
  endfunction

  function automatic logic [63:0] put_bytes(input logic [63:0] v, input logic [63:0] d,
                                            input logic [7:0] s);
    logic [63:0] r;
    r = v;
    for (int i = 0; i < 8; i++)
      if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mtime[k] = 64'h0;
      m_cmp[k]   = ALL1;
      m_msip[k]  = 1'b0;
      m_trint[k] = 1'b0;
      m_swint[k] = 1'b0;
      m_presc[k] = 0;
    end
  endtask

  // Advance one clock edge; commit=1 applies the pending write at this edge.
  task automatic edge_step(input bit commit);
    logic [63:0] nt;
    bit          tk;
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      tk         = (m_presc[k] == divof(k) - 1);
      m_trint[k] = (m_mtime[k] >= m_cmp[k]);
      m_swint[k] = m_msip[k];
      nt         = m_mtime[k] + (tk ? 64'd1 : 64'd0);
      m_presc[k] = tk ? 0 : m_presc[k] + 1;
      if (commit) begin
        if (p_off == 16'hBFF8) nt = put_bytes(nt, p_data, p_strb);
        if (p_off == 16'h4000) m_cmp[k] = put_bytes(m_cmp[k], p_data, p_strb);
        if (p_off == 16'h0000 && p_strb[0]) m_msip[k] = p_data[0];
      end
      m_mtime[k] = nt;
    end
    #1;
  endtask

  task automatic idle(input int n);
    b1.dreq.valid = 1'b0;
    repeat (n) edge_step(1'b0);
  endtask

  // One in-window transaction: accepted now, answered next cycle, committed at its close.
  task automatic txn(input logic [15:0] off, input logic [7:0] strb, input logic [63:0] data);
    b1.dreq.valid  = 1'b1;
    b1.dreq.addr   = {BASE[63:16], off[15:3], 3'($urandom_range(0, 7))};
    b1.dreq.size   = 3'($urandom_range(0, 3));
    b1.dreq.strobe = strb;
    b1.dreq.data   = data;
    p_off  = {off[15:3], 3'b000};
    p_strb = strb;
    p_data = data;
    exp0.push_back('{model_read(0, p_off), cyc + 1});
    exp1.push_back('{model_read(1, p_off), cyc + 1});
    edge_step(1'b0);
    edge_step(1'b1);
    b1.dreq.valid = 1'b0;
  endtask

  task automatic rd(input logic [15:0] off);
    txn(off, 8'h00, {$urandom, $urandom});
  endtask

  task automatic oow(input logic [63:0] addr, input int hold);
    b1.dreq.valid  = 1'b1;
    b1.dreq.addr   = addr;
    b1.dreq.size   = 3'd3;
    b1.dreq.strobe = 8'($urandom);
    b1.dreq.data   = {$urandom, $urandom};
    repeat (hold) edge_step(1'b0);
    b1.dreq.valid = 1'b0;
  endtask

  task automatic mon(input int k, input logic aok, input logic dok, input logic [63:0] d,
                     input logic t, input logic s);
    exp_t e;
    int   qn;
    check($sformatf("trint[%0d]", k), {63'h0, t}, {63'h0, m_trint[k]});
    check($sformatf("swint[%0d]", k), {63'h0, s}, {63'h0, m_swint[k]});
    if (dok) begin
      qn = (k == 0) ? exp0.size() : exp1.size();
      if (qn == 0) begin
        check($sformatf("unexpected_resp[%0d]", k), 64'd1, 64'd0);
      end else begin
        if (k == 0) e = exp0.pop_front();
        else        e = exp1.pop_front();
        check($sformatf("resp_data[%0d]", k), d, e.data);
        check($sformatf("resp_cycle[%0d]", k), 64'(cyc), 64'(e.cyc));
        check($sformatf("resp_addr_ok[%0d]", k), {63'h0, aok}, 64'd1);
      end
    end else begin
      check($sformatf("idle_data[%0d]", k), d, 64'h0);
      check($sformatf("idle_addr_ok[%0d]", k), {63'h0, aok}, 64'd0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, b1.dresp.addr_ok, b1.dresp.data_ok, b1.dresp.data, trint1, swint1);
      mon(1, b3.dresp.addr_ok, b3.dresp.data_ok, b3.dresp.data, trint3, swint3);
    end
  end

  initial begin
    logic [63:0] a, d;
    logic [7:0]  s;
    logic [15:0] off;
    int          sel;

    b1.dreq = '0;
    reset   = 1'b0;
    #1 reset = 1'b1;
    model_reset();
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset, then read mtime.
    idle(10);
    rd(16'hBFF8);

    // Software interrupt on/off, then only bit 0 of msip is kept.
    txn(16'h0000, 8'h01, 64'h1);
    idle(3);
    txn(16'h0000, 8'h01, 64'h0);
    idle(3);
    txn(16'h0000, 8'hFF, 64'hFFFF);
    rd(16'h0000);
    idle(2);

    // Timer compare crossing and clearing.
    txn(16'h4000, 8'hFF, 64'd20);
    txn(16'hBFF8, 8'hFF, 64'd15);
    idle(12);
    rd(16'hBFF8);
    txn(16'h4000, 8'hFF, ALL1);
    idle(3);

    // Partial mtime write racing a tick.
    txn(16'hBFF8, 8'hFF, 64'h0000_0007_FFFF_FFF0);
    txn(16'hBFF8, 8'h0F, 64'h1234_5678);
    rd(16'hBFF8);

    // mtime wrap and compare against a small mtimecmp.
    txn(16'hBFF8, 8'hFF, ALL1);
    rd(16'hBFF8);
    txn(16'h4000, 8'hFF, 64'd5);
    idle(4);
    rd(16'hBFF8);
    txn(16'h4000, 8'hFF, ALL1);

    // Out-of-window request held; unmapped in-window offset.
    oow(64'h0000_0000_8000_0000, 5);
    rd(16'h1000);
    txn(16'h1000, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D);
    rd(16'h1000);
    rd(16'h4000);

    // Reset during RESP: no response, then the request is re-issued.
    b1.dreq.valid  = 1'b1;
    b1.dreq.addr   = BASE + 64'hBFF8;
    b1.dreq.strobe = 8'h00;
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    b1.dreq.valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    rd(16'hBFF8);

    // Randomized traffic, mostly back-to-back.
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      s   = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom);
      d   = {$urandom, $urandom};
      case (sel)
        0, 1, 2: txn(16'h0000, s, d);
        3, 4: begin
          if ($urandom_range(0, 1) == 1) d = m_mtime[0] + 64'($urandom_range(0, 20));
          txn(16'h4000, s, d);
        end
        5, 6: txn(16'hBFF8, s, d);
        7: begin
          off = 16'($urandom);
          txn(off, s, d);
        end
        8: begin
          a = {$urandom, $urandom};
          if (a[63:16] == BASE[63:16]) a[40] = ~a[40];
          oow(a, $urandom_range(1, 3));
        end
        default: idle($urandom_range(1, 4));
      endcase
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(3);
    check("pending_resp[0]", 64'(exp0.size()), 64'd0);
    check("pending_resp[1]", 64'(exp1.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
